// File: rtl/aes_encryption_block.sv
// Iterative AES-128 encryption core: one round per clock, round keys
// expanded on the fly, ciphertext held in a register until the next run.
module aes_encryption_block (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         encryptEnable,
  input  logic [127:0] key,
  input  logic [127:0] inputData,
  output logic [127:0] outputData
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  // S-box table: entry 0 sits in the top byte, entry 255 in the bottom byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] out_q, out_d;

  logic [127:0] next_key;
  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;

  // Derive the next round key from the current one (RotWord, SubWord, Rcon).
  always_comb begin
    logic [31:0] rot;
    logic [31:0] temp;
    rot  = {rkey_q[23:0], rkey_q[31:24]};
    temp = {sbox(rot[31:24]) ^ rcon(round_q), sbox(rot[23:16]),
            sbox(rot[15:8]), sbox(rot[7:0])};
    next_key[127:96] = rkey_q[127:96] ^ temp;
    next_key[95:64]  = rkey_q[95:64]  ^ next_key[127:96];
    next_key[63:32]  = rkey_q[63:32]  ^ next_key[95:64];
    next_key[31:0]   = rkey_q[31:0]   ^ next_key[63:32];
  end

  // Round datapath: SubBytes, ShiftRows (row r rotates left by r), MixColumns.
  always_comb begin
    sub_bytes  = '0;
    shift_rows = '0;
    mix_cols   = '0;
    for (int i = 0; i < 16; i++) begin
      sub_bytes[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_cols[127-32*c -: 32] = mix_col(shift_rows[127-32*c -: 32]);
    end
  end

  // Sequencing: capture on enable, run ten rounds, publish, wait for enable low.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    out_d   = out_q;
    case (fsm_q)
      IDLE: begin
        if (encryptEnable) begin
          state_d = inputData ^ key;
          rkey_d  = key;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = ((round_q == 4'd10) ? shift_rows : mix_cols) ^ next_key;
        rkey_d  = next_key;
        round_d = round_q + 4'd1;
        if (round_q == 4'd10) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        out_d = state_q;
        if (!encryptEnable) begin
          fsm_d   = IDLE;
          round_d = 4'd0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that also aborts a running operation.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      rkey_q  <= '0;
      out_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      out_q   <= out_d;
    end
  end

  assign outputData = out_q;

endmodule

// File: tb/tb_aes_encryption_block.sv
// Self-checking bench for aes_encryption_block using known-answer vectors
// and a queue of expected ciphertexts.
module tb_aes_encryption_block;

  logic         clk;
  logic         n_rst;
  logic         encryptEnable;
  logic [127:0] key;
  logic [127:0] inputData;
  logic [127:0] outputData;

  int checks;
  int failures;
  logic [127:0] exp_q[$];
  logic [127:0] held;
  logic [127:0] expv;

  localparam logic [127:0] KEY_A = 128'h5E74E7BA66B0C7CC1B7697B3F9F51527;
  localparam logic [127:0] PT_A  = 128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D;
  localparam logic [127:0] CT_A  = 128'hDEB0F81341F3503A7CD01E2BC7CDD556;
  localparam logic [127:0] KEY_B = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] PT_B  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] CT_B  = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] CT_C  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  aes_encryption_block dut (
    .clk(clk),
    .n_rst(n_rst),
    .encryptEnable(encryptEnable),
    .key(key),
    .inputData(inputData),
    .outputData(outputData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and record its expected ciphertext; the next edge is k.
  task automatic start_op(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] ct);
    key           = k;
    inputData     = pt;
    encryptEnable = 1'b1;
    exp_q.push_back(ct);
  endtask

  // Drop enable for one edge so the core returns to IDLE.
  task automatic release_enable();
    encryptEnable = 1'b0;
    tick();
  endtask

  task automatic pop_expected();
    if (exp_q.size() == 0) begin
      failures++;
      checks++;
      $display("[TB] FAIL scoreboard_empty got=none required=entry");
      expv = 'x;
    end else begin
      expv = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    n_rst         = 1'b1;
    encryptEnable = 1'b0;
    key           = '0;
    inputData     = '0;
    tick();
    n_rst = 1'b0;
    checks++;
    if (outputData !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_value got=%h required=%h", outputData, 128'h0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (outputData !== 128'h0) begin
        failures++;
        $display("[TB] FAIL reset_hold cycle=%0d got=%h required=%h", i, outputData, 128'h0);
      end
    end
    held = 128'h0;
  endtask

  // Runs one operation from IDLE, checking hold at k+10 and the result at k+11.
  task automatic run_and_check(input string name, input logic [127:0] k,
                               input logic [127:0] pt, input logic [127:0] ct);
    start_op(k, pt, ct);
    tick();
    for (int i = 1; i <= 10; i++) tick();
    checks++;
    if (outputData !== held) begin
      failures++;
      $display("[TB] FAIL %s_early got=%h required=%h", name, outputData, held);
    end
    tick();
    pop_expected();
    checks++;
    if (outputData !== expv) begin
      failures++;
      $display("[TB] FAIL %s_result got=%h required=%h", name, outputData, expv);
    end
    held = expv;
  endtask

  task automatic test_vector_a();
    run_and_check("vector_a", KEY_A, PT_A, CT_A);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (outputData !== CT_A) begin
        failures++;
        $display("[TB] FAIL vector_a_hold cycle=%0d got=%h required=%h", i, outputData, CT_A);
      end
    end
  endtask

  task automatic test_fips_b();
    release_enable();
    run_and_check("fips_b", KEY_B, PT_B, CT_B);
  endtask

  task automatic test_back_to_back();
    release_enable();
    run_and_check("fips_c1", KEY_C, PT_C, CT_C);
  endtask

  task automatic test_midop_change();
    release_enable();
    start_op(KEY_A, PT_A, CT_A);
    tick();
    tick();
    tick();
    key       = '0;
    inputData = '0;
    for (int i = 3; i <= 10; i++) tick();
    checks++;
    if (outputData !== held) begin
      failures++;
      $display("[TB] FAIL midop_early got=%h required=%h", outputData, held);
    end
    tick();
    pop_expected();
    checks++;
    if (outputData !== expv) begin
      failures++;
      $display("[TB] FAIL midop_result got=%h required=%h", outputData, expv);
    end
    held = expv;
  endtask

  task automatic test_reset_midop();
    release_enable();
    key           = KEY_B;
    inputData     = PT_B;
    encryptEnable = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) tick();
    encryptEnable = 1'b0;
    n_rst         = 1'b1;
    tick();
    n_rst = 1'b0;
    checks++;
    if (outputData !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_midop_value got=%h required=%h", outputData, 128'h0);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (outputData !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_midop_idle got=%h required=%h", outputData, 128'h0);
    end
    held = 128'h0;
    run_and_check("after_reset", KEY_A, PT_A, CT_A);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    n_rst         = 1'b1;
    encryptEnable = 1'b0;
    key           = '0;
    inputData     = '0;
    held          = '0;
    test_reset();
    test_vector_a();
    test_fips_b();
    test_back_to_back();
    test_midop_change();
    test_reset_midop();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_encryption_block.md
Name: aes_encryption_block

Overview:
Iterative AES-128 encryption core (FIPS-197), one round per clock with on-the-fly key expansion. It captures a 128-bit key and plaintext block when enabled and produces the 128-bit ciphertext on a registered output, held stable until the next operation. It sits in the datapath between the host-side data/key registers and the ciphertext consumer.

Parameters:
None. AES-128 only: Nk=4, Nr=10.

Ports:
clk  input  1  system clock; all state updates on the rising edge
n_rst  input  1  reset, synchronous, active-high (asserted = 1), sampled on the clk rising edge
encryptEnable  input  1  level request to encrypt the current key/inputData
key  input  128  cipher key; bit 127 is the MSB of FIPS byte 0
inputData  input  128  plaintext block; bit 127 is the MSB of FIPS byte 0
outputData  output  128  registered ciphertext, same byte ordering

Behaviour:
- Byte order: byte i = bits [127-8i -: 8]; state column c = bytes 4c..4c+3 (FIPS column-major).
- Reset (n_rst=1 at a clk edge): FSM to IDLE, round counter 0, state/round-key registers 0, outputData = 0. Overrides everything, including mid-operation (abort, no output update).
- FSM states: IDLE, ROUND, DONE.
- IDLE: if encryptEnable=1 at edge k:
  - capture state = inputData XOR key (initial AddRoundKey);
  - round key = key; round = 1;
  - go to ROUND.
- ROUND, at edges k+1..k+10:
  - compute next round key combinationally from the current round key: RotWord, SubWord, Rcon[round] with Rcon = 01,02,04,08,10,20,40,80,1B,36.
  - apply SubBytes, ShiftRows, MixColumns (skipped when round=10), AddRoundKey; register the new state and round key; round++.
  - After round 10 (edge k+10), go to DONE.
- DONE: at edge k+11, outputData = final state. outputData changes only here or on reset.
- Latency: ciphertext is valid after edge k+11 (11 cycles after the enable sample) and is guaranteed by 17 cycles.
- Restart rule: DONE returns to IDLE only when encryptEnable=0. Holding encryptEnable high does not re-encrypt, so outputData stays stable. A new operation needs encryptEnable low for at least 1 cycle, then high.
- Changes on key, inputData or encryptEnable during ROUND are ignored; values are captured at edge k only.
- S-box: combinational 256-entry FIPS table, 16 instances for SubBytes plus 4 for SubWord.
- xtime(b) = (b<<1) XOR (b[7] ? 8'h1B : 0).
- MixColumns matrix rows: [02 03 01 01] [01 02 03 01] [01 01 02 03] [03 01 01 02].
- No X on outputData after reset. No combinational path from inputs to outputData.

Test Plan:
1. Reset: assert n_rst=1 for 1 edge with encryptEnable=0 -> outputData = 0, and stays 0 with enable low for 5 cycles.
2. Vector A: key=5E74E7BA66B0C7CC1B7697B3F9F51527, inputData=7D8AE0F7CFA0A6CB09FB5D05A8EC586D. Raise encryptEnable and hold it -> outputData = DEB0F81341F3503A7CD01E2BC7CDD556 by 17 cycles, exactly at edge k+11. Holding enable high 10 more cycles -> value unchanged.
3. FIPS-197 App. B: key=2B7E151628AED2A6ABF7158809CF4F3C, pt=3243F6A8885A308D313198A2E0370734 -> 3925841D02DC09FBDC118597196A0B32.
4. FIPS-197 App. C.1, back-to-back after 1 low cycle: key=000102030405060708090A0B0C0D0E0F, pt=00112233445566778899AABBCCDDEEFF -> 69C4E0D86A7B0430D8CDB78070B4C55A. The previous ciphertext holds until edge k+11.
5. Mid-operation change: start vector A, change key/inputData to all-zero at k+3 -> output still DEB0F813...D556.
6. Reset mid-operation: assert n_rst at k+5 -> outputData = 0, FSM IDLE. Re-enable with vector A -> correct ciphertext after 11 cycles.
